da_rom_sequencer: RTL

Bit-serial distributed-arithmetic (DA) controller for one DCT output coefficient. It accepts a group of four signed samples and walks their bits MSB-first, one bit per cycle. Each cycle it drives the chip-select and 3-bit address of an external 8-entry coefficient ROM (same port contract as the ROM2_Z2 family) and folds the returned partial sum into a shift-accumulator. One instance sits beside each coefficient ROM in the DCT stage. The result goes downstream over a valid/ready handshake.

---
 rtl/da_rom_sequencer.sv | 106 ++++++++++
 1 files changed

// File: rtl/da_rom_sequencer.sv
// Bit-serial distributed-arithmetic controller for one DCT coefficient: walks four
// captured samples MSB-first, addresses an 8-entry folded coefficient ROM and accumulates.
module da_rom_sequencer #(
  parameter int DW = 16,
  parameter int RW = 17,
  parameter int OW = RW + DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] x0,
  input  logic [DW-1:0] x1,
  input  logic [DW-1:0] x2,
  input  logic [DW-1:0] x3,
  output logic          rom_cs,
  output logic [2:0]    rom_addr,
  input  logic [RW-1:0] rom_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic          busy,
  output logic [1:0]    state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and the producer holds data stable until the transfer.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] CNT_MAX = CW'(DW - 1);

  logic [1:0]    state;
  logic          rdy_q;
  logic [CW-1:0] cnt;
  logic [DW-1:0] sx0, sx1, sx2, sx3;
  logic [OW-1:0] acc;

  logic          b0, b1, b2, b3;
  logic [OW-1:0] rom_ext;
  logic [OW-1:0] term;
  logic          accept;

  // Samples shift left, so the bit under examination is always the MSB of each register.
  assign b0 = sx0[DW-1];
  assign b1 = sx1[DW-1];
  assign b2 = sx2[DW-1];
  assign b3 = sx3[DW-1];

  assign rom_cs   = (state == S_RUN);
  assign rom_addr = rom_cs ? (b0 ? ~{b1, b2, b3} : {b1, b2, b3}) : 3'd0;
  assign rom_ext  = {{DW{rom_data[RW-1]}}, rom_data};
  assign term     = b0 ? -rom_ext : rom_ext;

  // rdy_q keeps in_ready low until the first edge after reset release.
  assign in_ready  = ((state == S_IDLE) && rdy_q) || ((state == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_DONE);
  assign out_data  = out_valid ? acc : '0;
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      rdy_q <= 1'b0;
      cnt   <= '0;
      sx0   <= '0;
      sx1   <= '0;
      sx2   <= '0;
      sx3   <= '0;
      acc   <= '0;
    end else begin
      rdy_q <= 1'b1;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            sx0   <= x0;
            sx1   <= x1;
            sx2   <= x2;
            sx3   <= x3;
            acc   <= '0;
            cnt   <= CNT_MAX;
            state <= S_RUN;
          end else if (state == S_DONE && out_ready) begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          // The sign-bit slice carries negative weight, hence the negated first term.
          acc <= (cnt == CNT_MAX) ? -term : ((acc << 1) + term);
          sx0 <= sx0 << 1;
          sx1 <= sx1 << 1;
          sx2 <= sx2 << 1;
          sx3 <= sx3 << 1;
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
